// File: rtl/wb_sched_pkg.sv
// wb_sched_pkg: shared widths and requester ids for the write-back scheduler.
package wb_sched_pkg;
    localparam int WB_XLEN = 32;
    localparam int RA_W    = 5;
    typedef enum logic {REQ_ALU = 1'b0, REQ_LOAD = 1'b1} req_id_e;
endpackage

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: two-port round-robin grant; ALU port favoured after reset.
module wb_rr_arbiter
    import wb_sched_pkg::*;
(
    input  logic CLK,
    input  logic reset,
    input  logic i_valid0,
    input  logic i_valid1,
    output logic o_grant0,
    output logic o_grant1
);
    req_id_e r_prio;
    logic    w_g0;
    logic    w_g1;

    assign w_g0     = i_valid0 & (~i_valid1 | (r_prio == REQ_ALU));
    assign w_g1     = i_valid1 & ~w_g0;
    // grants are forced low while reset is held
    assign o_grant0 = w_g0 & reset;
    assign o_grant1 = w_g1 & reset;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)    r_prio <= REQ_ALU;
        else if (w_g0) r_prio <= REQ_LOAD;
        else if (w_g1) r_prio <= REQ_ALU;
    end
endmodule

// File: rtl/wb_scheduler.sv
// wb_scheduler: arbitrates ALU/load write-backs into the register file and tracks pending writes.
// Define WB_BYPASS_EN to add forwarding outputs for writes in their rf_we cycle.
module wb_scheduler
    import wb_sched_pkg::*;
#(
    parameter int XLEN  = WB_XLEN,
    parameter int NREGS = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [RA_W-1:0]  req0_rd,
    input  logic [XLEN-1:0]  req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [RA_W-1:0]  req1_rd,
    input  logic [XLEN-1:0]  req1_data,
    output logic             req1_ready,
    output logic             rf_we,
    output logic [RA_W-1:0]  rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    input  logic             iss_valid,
    input  logic [RA_W-1:0]  iss_rd,
    output logic             iss_stall,
    input  logic [RA_W-1:0]  rs1,
    input  logic [RA_W-1:0]  rs2,
    output logic             rs1_busy,
    output logic             rs2_busy,
`ifdef WB_BYPASS_EN
    output logic             fwd1_hit,
    output logic             fwd2_hit,
    output logic [XLEN-1:0]  fwd1_data,
    output logic [XLEN-1:0]  fwd2_data,
`endif
    output logic             idle
);
    logic                   r_we;
    logic [RA_W-1:0]        r_waddr;
    logic [XLEN-1:0]        r_wdata;
    logic [(1<<RA_W)-1:0]   r_busy;
    logic [(1<<RA_W)-1:0]   w_busy_nxt;
    logic                   w_hs;
    logic [RA_W-1:0]        w_rd;
    logic [XLEN-1:0]        w_data;
    logic                   w_set;

    wb_rr_arbiter u_arb (
        .CLK      (CLK),
        .reset    (reset),
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .o_grant0 (req0_ready),
        .o_grant1 (req1_ready)
    );

    assign w_hs   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign w_rd   = req1_ready ? req1_rd : req0_rd;
    assign w_data = req1_ready ? req1_data : req0_data;

    assign iss_stall = iss_valid & r_busy[iss_rd];
    assign w_set     = iss_valid & ~iss_stall & (iss_rd != '0) & (32'(iss_rd) < NREGS);

    // set is applied after clear so a same-cycle reissue keeps the register busy
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we) w_busy_nxt[r_waddr] = 1'b0;
        if (w_set) w_busy_nxt[iss_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_busy  <= '0;
        end else begin
            r_we   <= w_hs & (w_rd != '0);
            r_busy <= w_busy_nxt;
            if (w_hs) begin
                r_waddr <= w_rd;
                r_wdata <= w_data;
            end
        end
    end

    assign rf_we    = r_we;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;
    assign idle     = ~|r_busy & ~r_we;

`ifdef WB_BYPASS_EN
    assign fwd1_hit  = r_we & (r_waddr == rs1) & (rs1 != '0);
    assign fwd2_hit  = r_we & (r_waddr == rs2) & (rs2 != '0);
    assign fwd1_data = r_wdata;
    assign fwd2_data = r_wdata;
    assign rs1_busy  = r_busy[rs1] & ~fwd1_hit;
    assign rs2_busy  = r_busy[rs2] & ~fwd2_hit;
`else
    assign rs1_busy  = r_busy[rs1];
    assign rs2_busy  = r_busy[rs2];
`endif
endmodule

// File: tb/tb_wb_scheduler.sv
// tb_wb_scheduler: scenario tasks with a write-back scoreboard checked on every rf_we pulse.
module tb_wb_scheduler;
    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        r0v = 0, r1v = 0, iv = 0;
    logic [4:0]  r0rd = 0, r1rd = 0, ir = 0, rs1 = 0, rs2 = 0;
    logic [31:0] r0d = 0, r1d = 0;
    logic        req0_ready, req1_ready, rf_we, iss_stall, rs1_busy, rs2_busy, idle;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef WB_BYPASS_EN
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;
`endif
    int          total = 0, bad = 0;
    logic        m_prio = 0;
    logic [36:0] sb[$];
    logic [36:0] exp_w;
    logic        e0, e1;

    always #5 CLK = ~CLK;

    wb_scheduler dut (
        .CLK(CLK), .reset(reset),
        .req0_valid(r0v), .req0_rd(r0rd), .req0_data(r0d), .req0_ready(req0_ready),
        .req1_valid(r1v), .req1_rd(r1rd), .req1_data(r1d), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .iss_valid(iv), .iss_rd(ir), .iss_stall(iss_stall),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef WB_BYPASS_EN
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
`endif
        .idle(idle)
    );

    // every register-file write is matched against the oldest expected transfer
    always @(negedge CLK) begin
        if (reset && rf_we) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_write got addr=%0d data=%0h exp no write", rf_waddr, rf_wdata);
            end else begin
                exp_w = sb.pop_front();
                if ({rf_waddr, rf_wdata} !== exp_w) begin
                    bad++;
                    $display("FAIL sb_write got=%0d/%0h exp=%0d/%0h", rf_waddr, rf_wdata, exp_w[36:32], exp_w[31:0]);
                end
            end
        end
    end

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic ivv, input logic [4:0] ird);
        @(posedge CLK);
        #1;
        r0v = v0; r0rd = a0; r0d = d0; r1v = v1; r1rd = a1; r1d = d1; iv = ivv; ir = ird;
        #1;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // reference arbitration: lone valid wins, contention goes to the port not granted last
    task automatic model_step(output logic g0, output logic g1);
        g0 = r0v && (!r1v || m_prio == 1'b0);
        g1 = r1v && !g0;
        if (g0) begin
            m_prio = 1'b1;
            if (r0rd != 0) sb.push_back({r0rd, r0d});
        end else if (g1) begin
            m_prio = 1'b0;
            if (r1rd != 0) sb.push_back({r1rd, r1d});
        end
    endtask

    task automatic apply_reset();
        @(posedge CLK);
        #1;
        reset = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        m_prio = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        reset = 0; r0v = 1; r1v = 1; iv = 1; ir = 3; rs1 = 3;
        #3;
        total++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready);
        end
        total++;
        if (idle !== 1'b1 || rf_we !== 1'b0) begin
            bad++; $display("FAIL reset_idle got idle=%b we=%b exp idle=1 we=0", idle, rf_we);
        end
        total++;
        if (iss_stall !== 1'b0 || rs1_busy !== 1'b0) begin
            bad++; $display("FAIL reset_hazard got stall=%b busy=%b exp 0 0", iss_stall, rs1_busy);
        end
        @(negedge CLK);
        r0v = 0; r1v = 0; iv = 0; ir = 0; rs1 = 0;
        @(negedge CLK);
        reset = 1'b1;
        m_prio = 1'b0;
        sb.delete();
    endtask

    task automatic test_basic();
        rs1 = 5;
        drive(0, 0, 0, 0, 0, 0, 1, 5);
        nop();
        total++;
        if (rs1_busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", rs1_busy); end
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        model_step(e0, e1);
        total++;
        if (req0_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", req0_ready); end
        nop();
        total++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL basic_write got=%b/%0d/%0h exp=1/5/deadbeef", rf_we, rf_waddr, rf_wdata);
        end
`ifdef WB_BYPASS_EN
        total++;
        if (rs1_busy !== 1'b0 || fwd1_hit !== 1'b1) begin
            bad++; $display("FAIL basic_fwd got busy=%b hit=%b exp 0 1", rs1_busy, fwd1_hit);
        end
`else
        total++;
        if (rs1_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_we got=%b exp=1", rs1_busy); end
`endif
        nop();
        total++;
        if (rs1_busy !== 1'b0 || idle !== 1'b1) begin
            bad++; $display("FAIL basic_clear got busy=%b idle=%b exp 0 1", rs1_busy, idle);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 10, 32'hA0 + i, 1, 11, 32'hB0 + i, 0, 0);
            model_step(e0, e1);
            total++;
            if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                bad++; $display("FAIL rr_grant%0d got=%b%b exp=%b%b", i, req0_ready, req1_ready, i % 2 == 0, i % 2 == 1);
            end
        end
        drive(0, 0, 0, 1, 12, 32'hC0, 0, 0);
        model_step(e0, e1);
        total++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            bad++; $display("FAIL rr_lone got=%b%b exp=01", req0_ready, req1_ready);
        end
        rs1 = 10;
        nop();
        nop();
        total++;
        if (rs1_busy !== 1'b0 || idle !== 1'b1) begin
            bad++; $display("FAIL rr_nonbusy got busy=%b idle=%b exp 0 1", rs1_busy, idle);
        end
    endtask

    task automatic test_rd_zero();
        drive(0, 0, 0, 1, 0, 32'h1234, 0, 0);
        model_step(e0, e1);
        total++;
        if (req1_ready !== 1'b1) begin bad++; $display("FAIL rd0_ready got=%b exp=1", req1_ready); end
        nop();
        total++;
        if (rf_we !== 1'b0 || idle !== 1'b1) begin
            bad++; $display("FAIL rd0_nowrite got we=%b idle=%b exp 0 1", rf_we, idle);
        end
    endtask

    task automatic test_waw();
        rs1 = 7;
        drive(0, 0, 0, 0, 0, 0, 1, 7);
        drive(0, 0, 0, 0, 0, 0, 1, 7);
        total++;
        if (iss_stall !== 1'b1 || rs1_busy !== 1'b1) begin
            bad++; $display("FAIL waw_stall got stall=%b busy=%b exp 1 1", iss_stall, rs1_busy);
        end
        drive(1, 7, 32'h77, 0, 0, 0, 0, 0);
        model_step(e0, e1);
        nop();
        nop();
        total++;
        if (rs1_busy !== 1'b0) begin bad++; $display("FAIL waw_cleared got=%b exp=0", rs1_busy); end
        drive(1, 7, 32'h88, 0, 0, 0, 0, 0);
        model_step(e0, e1);
        drive(0, 0, 0, 0, 0, 0, 1, 7);
        total++;
        if (iss_stall !== 1'b0 || rf_we !== 1'b1) begin
            bad++; $display("FAIL waw_same_cycle got stall=%b we=%b exp 0 1", iss_stall, rf_we);
        end
        nop();
        total++;
        if (rs1_busy !== 1'b1) begin bad++; $display("FAIL waw_set_wins got=%b exp=1", rs1_busy); end
        drive(1, 7, 32'h99, 0, 0, 0, 0, 0);
        model_step(e0, e1);
        nop();
        nop();
        total++;
        if (idle !== 1'b1) begin bad++; $display("FAIL waw_idle got=%b exp=1", idle); end
    endtask

    task automatic test_reset_mid();
        rs1 = 3;
        drive(1, 12, 32'hCAFE, 0, 0, 0, 1, 3);
        model_step(e0, e1);
        sb.delete();
        @(posedge CLK);
        #1;
        reset = 1'b0;
        r0v = 0; iv = 0; ir = 0; r0rd = 0; r0d = 0;
        #1;
        total++;
        if (rf_we !== 1'b0 || rs1_busy !== 1'b0 || idle !== 1'b1) begin
            bad++; $display("FAIL midreset_clear got we=%b busy=%b idle=%b exp 0 0 1", rf_we, rs1_busy, idle);
        end
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b1;
        m_prio = 1'b0;
        nop();
        nop();
        total++;
        if (rf_we !== 1'b0 || idle !== 1'b1 || rs1_busy !== 1'b0) begin
            bad++; $display("FAIL midreset_after got we=%b idle=%b busy=%b exp 0 1 0", rf_we, idle, rs1_busy);
        end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        rs1 = 0; rs2 = 9;
        drive(0, 0, 0, 0, 0, 0, 1, 9);
        drive(1, 9, 32'h55, 0, 0, 0, 0, 0);
        model_step(e0, e1);
        nop();
        total++;
        if (fwd2_hit !== 1'b1 || fwd2_data !== 32'h55 || rs2_busy !== 1'b0 || fwd1_hit !== 1'b0) begin
            bad++; $display("FAIL bypass got hit=%b data=%0h busy=%b hit1=%b exp 1 55 0 0", fwd2_hit, fwd2_data, rs2_busy, fwd1_hit);
        end
        nop();
        total++;
        if (fwd2_hit !== 1'b0 || rs2_busy !== 1'b0) begin
            bad++; $display("FAIL bypass_after got hit=%b busy=%b exp 0 0", fwd2_hit, rs2_busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_rd_zero();
        test_waw();
        test_reset_mid();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        nop();
        nop();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_missing got=%0d pending exp=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_scheduler.md
WB_SCHEDULER -- requirements
Module: wb_scheduler

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of every write-back path.
REQ-002 SHALL have parameter NREGS, default 32, number of architectural registers tracked (x0..x(NREGS-1)).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1  write-back request (port 0 = ALU, port 1 = load unit).
REQ-006 SHALL have ports req0_rd/req1_rd  input  5  destination register; req0_data/req1_data  input  XLEN  write data.
REQ-007 SHALL have ports req0_ready/req1_ready  output  1  grant; transfer occurs when valid and ready are both high.
REQ-008 SHALL have ports rf_we  output  1, rf_waddr  output  5, rf_wdata  output  XLEN, driving the register-file write port.
REQ-009 SHALL have ports iss_valid  input  1, iss_rd  input  5  issue of a new producer; iss_stall  output  1  WAW hold.
REQ-010 SHALL have ports rs1/rs2  input  5  source queries; rs1_busy/rs2_busy  output  1  pending-write hazard.
REQ-011 SHALL have port idle  output  1  high when no register is busy and rf_we is low.

Function
REQ-012 SHALL grant at most one requester per cycle; readyN combinational from valids and the round-robin pointer.
REQ-013 SHALL arbitrate round-robin: on contention, grant the port not granted last; a lone valid is granted immediately.
REQ-014 SHALL register the granted rd/data: rf_we/rf_waddr/rf_wdata valid exactly one cycle after the handshake (latency 1), rf_we high for one cycle per transfer.
REQ-015 SHALL accept requests with rd = 0 (ready asserted as normal) but keep rf_we low and leave the scoreboard unchanged.
REQ-016 SHALL hold a busy bit per register x1..x(NREGS-1); x0 is never busy.
REQ-017 SHALL set busy[iss_rd] on a cycle with iss_valid high, iss_rd != 0 and iss_stall low.
REQ-018 SHALL drive iss_stall = iss_valid and busy[iss_rd] (combinational); a stalled issue sets nothing.
REQ-019 SHALL clear busy[rf_waddr] on a cycle in which rf_we is high.
REQ-020 SHALL, when set and clear target the same register in one cycle, let set win (register stays busy).
REQ-021 SHALL drive rsN_busy = busy[rsN] combinationally; rsN = 0 gives 0.
REQ-022 SHALL not depend on requests matching a busy bit; a write to a non-busy register still writes and leaves busy clear.

Reset
REQ-023 SHALL, on reset low, asynchronously clear all busy bits, rf_we, rf_waddr, rf_wdata and the pointer (port 0 favoured first).
REQ-024 SHALL discard any registered write in flight when reset asserts mid-operation; no rf_we pulse after release until a new handshake.
REQ-025 SHALL drive req0_ready/req1_ready low, rsN_busy low, iss_stall low and idle high while reset is low.

Configuration
REQ-026 SHALL, with macro WB_BYPASS_EN defined, add outputs fwd1_hit/fwd2_hit (1) and fwd1_data/fwd2_data (XLEN): hit = rf_we and rf_waddr == rsN != 0, data = rf_wdata, and rsN_busy masked low on a hit.
REQ-027 SHALL, without WB_BYPASS_EN, omit those ports entirely; rsN_busy stays high until the cycle after rf_we.

Structure
REQ-028 SHALL take XLEN, the register-address width (5) and requester index constants (ALU = 0, LOAD = 1) from shared package wb_sched_pkg.
REQ-029 SHALL place the round-robin grant logic in one sub-module, wb_rr_arbiter; scoreboard and output register stay in wb_scheduler.

Verification
REQ-030 SHALL cover: iss_valid, iss_rd = 5 -> rs1 = 5 busy; req0 rd = 5, data 0xDEADBEEF -> next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF; following cycle rs1_busy = 0.
REQ-031 SHALL cover: both valid for 4 cycles from reset -> grants 0, 1, 0, 1; rf_wdata order matches.
REQ-032 SHALL cover: req1 rd = 0, data 0x1234 -> req1_ready = 1, rf_we stays 0, idle stays 1.
REQ-033 SHALL cover: x7 busy, iss_valid iss_rd = 7 -> iss_stall = 1; same-cycle rf_we to x7 with new issue of x7 -> x7 remains busy.
REQ-034 SHALL cover: reset low one cycle after a handshake -> no rf_we pulse, all busy clear, idle = 1 after release.
REQ-035 SHALL cover (WB_BYPASS_EN): rf_we to x9 data 0x55, rs2 = 9 -> fwd2_hit = 1, fwd2_data = 0x55, rs2_busy = 0.
